// File: rtl/spi_slave_sync_pkg.sv
// Shared types and constants for the spi_slave_sync block.
package spi_slave_sync_pkg;

  // Word-level FSM state encoding.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } state_e;

  // SCLK idle level selection.
  localparam int unsigned CpolIdleLow  = 0;
  localparam int unsigned CpolIdleHigh = 1;

  // Phase selection: which SCLK edge samples MOSI.
  localparam int unsigned CphaLeadSample  = 0;
  localparam int unsigned CphaTrailSample = 1;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized value.
module spi_sync_edge #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  // Shift the raw input through the synchronizer; keep one more stage for edges.
  always_comb begin
    sync_d = {sync_q[0], d_i};
    prev_d = sync_q[1];
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RstVal}};
      prev_q <= RstVal;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge strobes are one clk wide.
  always_comb begin
    level_o = sync_q[1];
    rise_o  = sync_q[1] & ~prev_q;
    fall_o  = ~sync_q[1] & prev_q;
  end

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave sampled in the clk domain. Optional miso_oe output is enabled by
// defining SPI_SLAVE_MISO_OE_EN.
module spi_slave_sync
  import spi_slave_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CPOL       = CpolIdleLow,
  parameter int unsigned CPHA       = CphaTrailSample
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                  miso_oe,
`endif
  input  logic [DATA_WIDTH-1:0] data_send,
  output logic [DATA_WIDTH-1:0] data_recv,
  output logic                  spi_done
);

  localparam int unsigned     CntW          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit       = CntW'(DATA_WIDTH - 1);
  localparam logic            SclkIdle      = (CPOL == CpolIdleHigh);
  localparam logic            SampleOnTrail = (CPHA == CphaTrailSample);

  logic                  sclk_s, sclk_rise, sclk_fall, sclk_edge;
  logic                  cs_n_s, cs_rise, cs_fall;
  logic [1:0]            mosi_sync_q, mosi_sync_d;
  logic                  mosi_s;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, recv_q, recv_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  miso_q, miso_d;
  logic                  lead_edge, trail_edge, sample_edge, shift_edge;
  logic                  load, last_sample;

  spi_sync_edge #(
    .RstVal(SclkIdle)
  ) u_sync_sclk (
    .clk_i  (clk),
    .rst_ni (arstn),
    .d_i    (sclk),
    .level_o(sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(
    .RstVal(1'b1)
  ) u_sync_cs (
    .clk_i  (clk),
    .rst_ni (arstn),
    .d_i    (cs_n),
    .level_o(cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI synchronizer, same latency as the SCLK path so samples line up.
  always_comb begin
    mosi_sync_d = {mosi_sync_q[0], mosi};
    mosi_s      = mosi_sync_q[1];
  end

  // Classify SCLK edges relative to the idle level, then map to sample/shift.
  always_comb begin
    sclk_edge   = sclk_rise | sclk_fall;
    lead_edge   = sclk_edge & (sclk_s != SclkIdle);
    trail_edge  = sclk_edge & (sclk_s == SclkIdle);
    sample_edge = SampleOnTrail ? trail_edge : lead_edge;
    shift_edge  = SampleOnTrail ? lead_edge : trail_edge;
  end

  // Next-state, shift register and counter logic.
  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    miso_d      = miso_q;
    recv_d      = recv_q;
    load        = 1'b0;
    last_sample = sample_edge && (cnt_q == LastBit);

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d = StActive;
          load    = 1'b1;
        end
      end
      StActive: begin
        if (sample_edge) begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d = last_sample ? '0 : cnt_q + CntW'(1);
          if (last_sample) begin
            recv_d  = rx_d;
            state_d = StDone;
          end
        end
        // A completing sample wins over a simultaneous deselect.
        if (cs_rise && !last_sample) begin
          state_d = StIdle;
        end
        // With CPHA=0 the trailing edge after the last sample belongs to the old
        // word (count already wrapped to 0) and must not shift the reloaded word.
        if (shift_edge && (SampleOnTrail || (cnt_q != '0))) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
      end
      StDone: begin
        if (cs_n_s) begin
          state_d = StIdle;
        end else begin
          state_d = StActive;
          load    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      if (SampleOnTrail) begin
        tx_d = data_send;
      end else begin
        tx_d   = {data_send[DATA_WIDTH-2:0], 1'b0};
        miso_d = data_send[DATA_WIDTH-1];
      end
    end

    // Leaving for IDLE drops any partial word and silences miso.
    if (state_d == StIdle) begin
      tx_d   = '0;
      rx_d   = '0;
      cnt_d  = '0;
      miso_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mosi_sync_q <= 2'b00;
      state_q     <= StIdle;
      tx_q        <= '0;
      rx_q        <= '0;
      recv_q      <= '0;
      cnt_q       <= '0;
      miso_q      <= 1'b0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      recv_q      <= recv_d;
      cnt_q       <= cnt_d;
      miso_q      <= miso_d;
    end
  end

  // Outputs.
  always_comb begin
    miso      = miso_q;
    data_recv = recv_q;
    spi_done  = (state_q == StDone);
`ifdef SPI_SLAVE_MISO_OE_EN
    miso_oe   = (state_q != StIdle);
`endif
  end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word length in bits.
REQ-002 SHALL have parameter CPOL, default 0, SCLK idle level (0: idle low; 1: idle high).
REQ-003 SHALL have parameter CPHA, default 1 (0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing).
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-005 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-007 SHALL have port cs_n  input  1  chip select, active-low, asynchronous to clk.
REQ-008 SHALL have port mosi  input  1  serial data from master.
REQ-009 SHALL have port miso  output  1  serial data to master.
REQ-010 SHALL have port data_send  input  DATA_WIDTH  word to transmit, captured at word start.
REQ-011 SHALL have port data_recv  output  DATA_WIDTH  last complete received word.
REQ-012 SHALL have port spi_done  output  1  one-clk pulse per completed word.

Function
REQ-013 SHALL pass sclk, cs_n, mosi each through a 2-flop synchronizer; all edge detection uses synchronized values; clk frequency SHALL be at least 4x SCLK.
REQ-014 SHALL implement FSM IDLE -> ACTIVE -> DONE -> (ACTIVE if cs_n low, else IDLE).
REQ-015 IDLE: on synchronized cs_n falling, load data_send into TX shift register, clear bit counter, enter ACTIVE.
REQ-016 Leading edge = synchronized sclk leaving CPOL level; trailing edge = return to CPOL level.
REQ-017 Bit order SHALL be MSB first for both directions.
REQ-018 CPHA=0: miso SHALL present TX MSB in the clk cycle after cs_n fall is detected; shift on trailing edges; sample mosi on leading edges.
REQ-019 CPHA=1: shift TX on leading edges (first leading edge presents MSB); sample mosi on trailing edges.
REQ-020 Bit counter SHALL count sample edges 0..DATA_WIDTH-1 and wrap to 0 at word end.
REQ-021 On the DATA_WIDTH-th sample, data_recv SHALL update with the full RX word and FSM enters DONE for exactly one clk, during which spi_done=1.
REQ-022 In DONE with cs_n still low, data_send SHALL be reloaded into TX register for a back-to-back word without gap.
REQ-023 Synchronized cs_n rising mid-word SHALL abort: partial bits discarded, data_recv unchanged, no spi_done, return to IDLE.
REQ-024 cs_n rising in the same clk as the final sample SHALL still complete the word (spi_done pulses), then IDLE.
REQ-025 miso SHALL be 0 whenever FSM is IDLE.
REQ-026 spi_done SHALL assert no later than 4 clk after the raw final sample edge of sclk.

Reset
REQ-027 arstn low SHALL immediately force: FSM=IDLE, miso=0, spi_done=0, data_recv=0, shift registers and bit counter=0, synchronizer flops to CPOL / 1 / 0 for sclk / cs_n / mosi.
REQ-028 Reset mid-word SHALL discard the word; after release the block waits for a fresh cs_n falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_MISO_OE_EN defined: SHALL add output miso_oe (1 bit), high exactly while FSM is not IDLE, low at reset.
REQ-030 Macro SPI_SLAVE_MISO_OE_EN undefined: SHALL have no miso_oe port; miso behaviour otherwise identical.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE, ACTIVE, DONE) and CPOL/CPHA constant names.
REQ-032 Sub-module spi_sync_edge SHALL implement the 2-flop synchronizer plus rise/fall detect, instantiated for sclk and cs_n.

Verification
REQ-033 CPOL=0, CPHA=1, data_send=8'hCD, master sends 8'hAB -> data_recv=8'hAB, master receives 8'hCD, one spi_done pulse.
REQ-034 All four CPOL/CPHA combos, master 8'h5A, slave 8'hA5 -> both ends receive correct byte.
REQ-035 Two back-to-back words with cs_n held low (master 8'hEE,8'h11; data_send 8'hFF then 8'h22 changed after first spi_done) -> two spi_done pulses, data_recv 8'hEE then 8'h11, master gets 8'hFF then 8'h22.
REQ-036 cs_n raised after 5 of 8 bits -> no spi_done, data_recv keeps prior value 8'hAB, miso=0.
REQ-037 arstn asserted after 3 bits, released, then full word 8'h3C -> data_recv=8'h3C, exactly one spi_done.
REQ-038 With SPI_SLAVE_MISO_OE_EN: miso_oe high from cs_n fall detect to return to IDLE, low otherwise.
